io_uart_tx: RTL

Memory-mapped serial output peripheral that sits directly downstream of the bit16 core's I/O port. It consumes the 16-bit words the core stores to its I/O address, buffers them in a small FIFO, and serialises each word as two 8N1 UART frames, low byte first. The status word it returns is fed back to the core's `io_in`, so software can poll for room before storing.

---
 rtl/io_pkg.sv | 39 +++
 rtl/io_uart_tx_if.sv | 32 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/io_uart_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : io_pkg                                                     |
// | Brief   : Shared encodings for the bit16 I/O port peripherals.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package io_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int ST_BUSY  = 15;
    localparam int ST_FULL  = 14;
    localparam int ST_EMPTY = 13;
    localparam int ST_OVF   = 12;

    // Data-memory address the core stores to / loads from for this port.
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    function automatic logic [15:0] pack_status(input logic        busy,
                                                input logic        full,
                                                input logic        empty,
                                                input logic        ovf,
                                                input logic [11:0] level);
        logic [15:0] s;
        s           = {4'd0, level};
        s[ST_BUSY]  = busy;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : io_uart_tx_if                                              |
// | Brief   : Core-side write/status bundle of the UART transmitter.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface io_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    logic            wr_en;
    logic [15:0]     wr_data;
    logic            tx;
    logic            busy;
    logic            full;
    logic            empty;
    logic [c_LW-1:0] level;
    logic            ovf;
    logic [15:0]     status;

    modport master (
        output wr_en, wr_data,
        input  tx, busy, full, empty, level, ovf, status
    );

    modport slave (
        input  wr_en, wr_data,
        output tx, busy, full, empty, level, ovf, status
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_fifo                                                  |
// | Brief   : Single-clock fall-through FIFO, power-of-2 depth.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB tells a full FIFO from an empty one when indices match.
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : io_uart_tx                                                 |
// | Brief   : Buffered 16-bit word to two 8N1 frames (low byte first).   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    io_uart_tx_if.slave  bus
);
    localparam int              c_LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              c_CW       = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [15:0]     r_hold, w_hold_nxt;
    logic            r_sel, w_sel_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_ovf;
    logic            w_pop;
    logic            w_cnt_last;
    logic [7:0]      w_byte_nxt;
    logic [15:0]     w_fifo_dout;
    logic            w_full;
    logic            w_empty;
    logic [c_LW-1:0] w_level;
    logic            w_busy;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (w_pop),
        .din   (bus.wr_data),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_sel_nxt   = r_sel;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = w_fifo_dout;
                    w_sel_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end
            end
            S_STOP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (!r_sel) begin
                        w_sel_nxt   = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line level is decoded from next-state so tx can be a plain flop.
    always_comb begin
        w_byte_nxt = w_sel_nxt ? w_hold_nxt[15:8] : w_hold_nxt[7:0];
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_byte_nxt[w_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_hold  <= 16'd0;
            r_sel   <= 1'b0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_sel   <= w_sel_nxt;
            r_tx    <= w_tx_nxt;
            if (bus.wr_en && w_full) r_ovf <= 1'b1;
        end
    end

    assign w_busy     = (r_state != S_IDLE);
    assign bus.tx     = r_tx;
    assign bus.busy   = w_busy;
    assign bus.full   = w_full;
    assign bus.empty  = w_empty;
    assign bus.level  = w_level;
    assign bus.ovf    = r_ovf;
    assign bus.status = pack_status(w_busy, w_full, w_empty, r_ovf, 12'(w_level));
endmodule
`default_nettype wire
